alu_pipe_cc: RTL and testbench
==============================

# alu_pipe_cc

Parametrised, pipelined successor to the fixed 64-bit bitwise units in the Execute stage ALU block. It performs the four Y86-64 OPq functions (add, sub, and, xor) at a configurable width. Operands and results move through a two-stage valid/ready pipeline. An architectural condition-code register (ZF, SF, OF) is updated on request when each result retires.

## Interface
- WIDTH, 64: operand/result width in bits; must be 8 or more.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_ifun  in  4  function code: 0 add, 1 sub, 2 and, 3 xor; 4–15 illegal
- in_a  in  WIDTH  operand A (valA), two's complement
- in_b  in  WIDTH  operand B (valB), two's complement
- in_set_cc  in  1  this beat updates the CC register when it retires
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts the result
- out_result  out  WIDTH  valE
- out_zf, out_sf, out_of  out  1 each  flags computed for this beat
- out_err  out  1  beat carried an illegal ifun
- cc_zf, cc_sf, cc_of  out  1 each  architectural condition codes

## Operation
- Stage 1 registers in_ifun, in_a, in_b and in_set_cc, plus a valid bit s1_valid.
- Stage 2 computes the result from the stage-1 registers. It registers the result and flags into the out_* outputs and out_valid.
- Functions (computed at WIDTH bits, wrap-around, no carry out):
  - add: b + a
  - sub: b − a
  - and: b & a
  - xor: b ^ a
- Flags:
  - ZF = (result == 0).
  - SF = result[WIDTH−1].
  - OF for add = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]).
  - OF for sub = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]).
  - OF for and/xor = 0.
- Illegal ifun (4–15): out_result = 0, out_zf/out_sf/out_of = 0, out_err = 1. The CC register is never updated for this beat, regardless of set_cc.
- CC register update: on the cycle out_valid && out_ready holds for a legal beat whose set_cc was 1, the register takes out_zf/out_sf/out_of. It updates at the following edge.
- Beats with set_cc = 0 pass through without touching the CC register.
- Handshake rules:
  - A transfer occurs on any edge where valid && ready.
  - in_a, in_b, in_ifun and in_set_cc are sampled only on input transfer.
  - While out_valid && !out_ready, all out_* outputs hold stable.
- Ready propagation:
  - adv2 = !out_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1 (combinational from out_ready; no registered skid buffer)

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - s1_valid = 0, out_valid = 0
  - out_result = 0, out_zf = out_sf = out_of = 0, out_err = 0
  - cc_zf = 1, cc_sf = 0, cc_of = 0 (Y86 reset CC)
  - in_ready = 1 on the first cycle after release
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+1, provided there is no backpressure.
- Throughput: one beat per cycle while out_ready = 1.
- Backpressure: with out_ready held at 0, the block absorbs exactly two beats, then in_ready = 0. Both beats are delivered in order with no loss or duplication once out_ready rises.
- Simultaneous events: on an edge with output transfer and input transfer together, stage 2 takes the stage-1 beat and stage 1 takes the new beat.
- CC timing: cc_* change one edge after the retiring transfer. Back-to-back set_cc beats update CC on consecutive edges.
- Reset mid-operation: all in-flight beats are discarded with no partial output, and CC returns to Z=1, S=0, O=0.

## Test plan
- XOR, WIDTH=64: a = 0xF0F0F0F0F0F0F0F4, b = 0xCCCCCCCCCCCCCCC5, ifun 3 → out_result = 0x3C3C3C3C3C3C3C31, ZF = 0, SF = 0, OF = 0, out_valid 2 cycles after acceptance.
- Add overflow with set_cc=1: a = 1, b = 0x7FFFFFFFFFFFFFFF → result 0x8000000000000000, SF = 1, OF = 1, ZF = 0. cc_* = 0/1/1 one edge after the output transfer.
- Sub zero, then and without set_cc: first a = 5, b = 5, ifun 1, set_cc = 1 → result 0, cc_zf = 1. Next a = 0, b = 0xFF, ifun 2, set_cc = 0 → result 0, out_zf = 1, CC unchanged.
- Backpressure: stream 4 add beats with out_ready = 0 → in_ready drops after 2 accepts. Raise out_ready → all 4 results emerge in order; outputs stay stable while stalled.
- Illegal ifun 7 with set_cc = 1 → out_err = 1, out_result = 0, cc_* unchanged.
- Reset and width:
  - With 2 beats in flight, pulse rst_n low → out_valid = 0 immediately and CC = 1/0/0.
  - At WIDTH=8, sub a = 0x01, b = 0x80 → result 0x7F, OF = 1, SF = 0.

Source files
------------

// File: rtl/alu_pipe_cc.sv
// alu_pipe_cc: two-stage valid/ready pipelined Y86-64 OPq ALU (add, sub, and, xor)
// with a configurable width and an architectural ZF/SF/OF condition-code register.
// Stage 1 captures operands; stage 2 computes and registers the result and flags;
// the CC register commits a retiring beat's flags one edge after its output transfer.
module alu_pipe_cc #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ifun,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of,
  output logic             out_err,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam int MSB = WIDTH - 1;

  // Y86 function codes handled by this block
  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_XOR = 4'd3;

  // Stage-1 operand registers
  logic             s1_valid;
  logic [3:0]       s1_ifun;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_set_cc;

  // set_cc travels alongside the stage-2 result so the CC write can be qualified at retirement
  logic             s2_set_cc;

  // Combinational stage-2 results computed from the stage-1 registers
  logic [WIDTH-1:0] result_next;
  logic             zf_next;
  logic             sf_next;
  logic             of_next;
  logic             err_next;

  logic             adv1;
  logic             adv2;
  logic             retire_cc;

  // Ready chain: stage 2 can move when empty or draining; stage 1 when empty or stage 2 moves
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // CC is written only by a legal beat that requested it, on its output transfer
  assign retire_cc = out_valid && out_ready && !out_err && s2_set_cc;

  // ALU function and flag generation; illegal codes yield an all-zero result with err set
  always_comb begin
    result_next = '0;
    of_next     = 1'b0;
    err_next    = 1'b0;
    case (s1_ifun)
      FN_ADD: begin
        result_next = s1_b + s1_a;
        of_next     = (s1_a[MSB] == s1_b[MSB]) && (result_next[MSB] != s1_a[MSB]);
      end
      FN_SUB: begin
        result_next = s1_b - s1_a;
        of_next     = (s1_a[MSB] != s1_b[MSB]) && (result_next[MSB] != s1_b[MSB]);
      end
      FN_AND:  result_next = s1_b & s1_a;
      FN_XOR:  result_next = s1_b ^ s1_a;
      default: err_next = 1'b1;
    endcase
    zf_next = !err_next && (result_next == '0);
    sf_next = result_next[MSB];
  end

  // Stage 1: capture a beat whenever this stage is free to advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_ifun   <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_set_cc <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ifun   <= in_ifun;
        s1_a      <= in_a;
        s1_b      <= in_b;
        s1_set_cc <= in_set_cc;
      end
    end
  end

  // Stage 2: register result and flags; hold everything while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zf     <= 1'b0;
      out_sf     <= 1'b0;
      out_of     <= 1'b0;
      out_err    <= 1'b0;
      s2_set_cc  <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= result_next;
        out_zf     <= zf_next;
        out_sf     <= sf_next;
        out_of     <= of_next;
        out_err    <= err_next;
        s2_set_cc  <= s1_set_cc;
      end
    end
  end

  // Architectural condition codes, reset to the Y86 power-on value Z=1 S=0 O=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (retire_cc) begin
      cc_zf <= out_zf;
      cc_sf <= out_sf;
      cc_of <= out_of;
    end
  end

endmodule

// File: tb/tb_alu_pipe_cc.sv
// tb_alu_pipe_cc: scoreboard bench for alu_pipe_cc. A driver pushes the expected
// response of each accepted beat into a queue; an independent monitor drives
// out_ready, pops on every output transfer, tracks the expected CC register and
// checks that stalled outputs hold. A second 8-bit instance covers the narrow width.
module tb_alu_pipe_cc;

  typedef struct {
    logic [63:0] res;
    logic        z;
    logic        s;
    logic        o;
    logic        err;
    logic        sc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_set_cc;
  logic [3:0]  in_ifun;
  logic [63:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic        out_zf, out_sf, out_of, out_err;
  logic        cc_zf, cc_sf, cc_of;

  logic        v8, rdy8, ov8, sc8;
  logic [3:0]  f8;
  logic [7:0]  a8, b8, res8;
  logic        z8, s8, o8, e8, cz8, cs8, co8;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          mode;          // 0 random out_ready, 1 hold low, 2 hold high
  logic [2:0]  exp_cc;        // expected {zf,sf,of}

  always #5 clk = ~clk;

  alu_pipe_cc #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ifun(in_ifun),
    .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zf(out_zf), .out_sf(out_sf), .out_of(out_of), .out_err(out_err),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  alu_pipe_cc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(rdy8), .in_ifun(f8),
    .in_a(a8), .in_b(b8), .in_set_cc(sc8),
    .out_valid(ov8), .out_ready(1'b1), .out_result(res8),
    .out_zf(z8), .out_sf(s8), .out_of(o8), .out_err(e8),
    .cc_zf(cz8), .cc_sf(cs8), .cc_of(co8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] r, input logic z, s, o, err, sc);
    exp_t e;
    e.res = r; e.z = z; e.s = s; e.o = o; e.err = err; e.sc = sc;
    return e;
  endfunction

  // Reference: exact signed arithmetic at 66 bits; overflow means the true value left the 64-bit range
  function automatic exp_t model(input logic [63:0] a, b, input logic [3:0] f, input logic sc);
    exp_t e;
    logic signed [65:0] sa, sb, t;
    sa = {{2{a[63]}}, a};
    sb = {{2{b[63]}}, b};
    e = mk(64'd0, 1'b0, 1'b0, 1'b0, 1'b0, sc);
    case (f)
      4'd0, 4'd1: begin
        t = (f == 4'd0) ? sb + sa : sb - sa;
        e.res = t[63:0];
        e.o = (t > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (t < -66'sh0_8000_0000_0000_0000);
      end
      4'd2:    e.res = a & b;
      4'd3:    e.res = a ^ b;
      default: e.err = 1'b1;
    endcase
    e.z = !e.err && (e.res == 64'd0);
    e.s = e.res[63];
    return e;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom_range(0, 3));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Offer one beat each negedge until accepted or the budget runs out; in_valid stays high on return
  task automatic send(input logic [63:0] a, b, input logic [3:0] f, input logic sc,
                      input exp_t e, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_ifun = f; in_set_cc = sc;
      #2;
      if (in_ready) begin
        q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic stop_in();
    @(negedge clk);
    in_valid = 1'b0;
    #2;
  endtask

  task automatic drain();
    stop_in();
    mode = 2;
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0 && !out_valid) break;
      @(negedge clk);
      #2;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    @(negedge clk);
    #2;
  endtask

  // Monitor: drives out_ready, checks CC, stall stability and every retiring beat
  initial begin : monitor
    exp_t        e;
    logic        stall_prev;
    logic [67:0] held;
    stall_prev = 1'b0;
    held = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
      #1;
      if (!rst_n) begin
        stall_prev = 1'b0;
        continue;
      end
      chk("cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, exp_cc});
      if (stall_prev)
        chk("stall_hold", {out_valid, out_err, out_zf, out_sf}, held[67:64]);
      if (stall_prev)
        chk("stall_result", out_result, held[63:0]);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("result", out_result, e.res);
          chk("flags", {60'd0, out_err, out_zf, out_sf, out_of}, {60'd0, e.err, e.z, e.s, e.o});
          if (!e.err && e.sc) exp_cc = {e.z, e.s, e.o};
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_valid, out_err, out_zf, out_sf, out_result};
    end
  end

  // Driver: directed scenarios, then randomized traffic, then reset mid-operation
  initial begin : driver
    bit ok;
    logic [63:0] ra, rb;
    logic [3:0]  rf;
    logic        rsc;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_ifun = '0; in_set_cc = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; f8 = '0; sc8 = 1'b0;
    mode = 2; exp_cc = 3'b100;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_flags", {60'd0, out_err, out_zf, out_sf, out_of}, 64'd0);
    chk("rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'd4);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // 8-bit sub: 0x80 - 0x01 = 0x7F overflows
    @(negedge clk);
    v8 = 1'b1; a8 = 8'h01; b8 = 8'h80; f8 = 4'd1;
    #2;
    chk("w8_in_ready", {63'd0, rdy8}, 64'd1);
    @(negedge clk);
    v8 = 1'b0;
    #2;
    chk("w8_early", {63'd0, ov8}, 64'd0);
    @(negedge clk);
    #2;
    chk("w8_valid", {63'd0, ov8}, 64'd1);
    chk("w8_result", {56'd0, res8}, 64'h7F);
    chk("w8_flags", {60'd0, e8, z8, s8, o8}, 64'b0001);

    // XOR with latency check
    send(64'hF0F0F0F0F0F0F0F4, 64'hCCCCCCCCCCCCCCC5, 4'd3, 1'b0,
         mk(64'h3C3C3C3C3C3C3C31, 0, 0, 0, 0, 0), 5, ok);
    chk("xor_accept", {63'd0, ok}, 64'd1);
    stop_in();
    chk("xor_lat1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    #2;
    chk("xor_lat2", {63'd0, out_valid}, 64'd1);
    drain();

    // CC sequence: sub zero (cc 100), add overflow (cc 011), and without set_cc, illegal with set_cc
    send(64'd5, 64'd5, 4'd1, 1'b1, mk(64'd0, 1, 0, 0, 0, 1), 5, ok);
    send(64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'd0, 1'b1,
         mk(64'h8000_0000_0000_0000, 0, 1, 1, 0, 1), 5, ok);
    send(64'd0, 64'hFF, 4'd2, 1'b0, mk(64'd0, 1, 0, 0, 0, 0), 5, ok);
    send(64'd3, 64'd9, 4'd7, 1'b1, mk(64'd0, 0, 0, 0, 1, 1), 5, ok);
    drain();
    chk("cc_after_directed", {61'd0, cc_zf, cc_sf, cc_of}, 64'b011);

    // Backpressure: two beats absorbed, third blocked, all four delivered in order
    mode = 1;
    send(64'd1, 64'd10, 4'd0, 1'b0, mk(64'd11, 0, 0, 0, 0, 0), 4, ok);
    chk("bp_accept0", {63'd0, ok}, 64'd1);
    send(64'd2, 64'd20, 4'd0, 1'b0, mk(64'd22, 0, 0, 0, 0, 0), 4, ok);
    chk("bp_accept1", {63'd0, ok}, 64'd1);
    send(64'd3, 64'd30, 4'd0, 1'b0, mk(64'd33, 0, 0, 0, 0, 0), 3, ok);
    chk("bp_blocked", {63'd0, ok}, 64'd0);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    mode = 2;
    send(64'd3, 64'd30, 4'd0, 1'b0, mk(64'd33, 0, 0, 0, 0, 0), 10, ok);
    chk("bp_accept2", {63'd0, ok}, 64'd1);
    send(64'd4, 64'd40, 4'd0, 1'b0, mk(64'd44, 0, 0, 0, 0, 0), 10, ok);
    chk("bp_accept3", {63'd0, ok}, 64'd1);
    drain();

    // Randomized traffic against the reference model
    mode = 0;
    for (int n = 0; n < 300; n++) begin
      ra = pick();
      rb = pick();
      rf = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      rsc = 1'($urandom_range(0, 1));
      send(ra, rb, rf, rsc, model(ra, rb, rf, rsc), 50, ok);
      chk("rand_accept", {63'd0, ok}, 64'd1);
      if ($urandom_range(0, 3) == 0) stop_in();
    end
    drain();

    // Reset with two beats in flight
    mode = 1;
    send(64'd1, 64'd1, 4'd1, 1'b1, mk(64'd0, 1, 0, 0, 0, 1), 4, ok);
    send(64'd7, 64'd8, 4'd3, 1'b1, mk(64'd15, 0, 0, 0, 0, 1), 4, ok);
    stop_in();
    chk("mid_in_flight", {63'd0, out_valid}, 64'd1);
    mode = 2;
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    exp_cc = 3'b100;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
    send(64'd2, 64'd1, 4'd1, 1'b1, mk('1, 0, 1, 0, 0, 1), 5, ok);
    chk("post_rst_accept", {63'd0, ok}, 64'd1);
    drain();
    chk("post_rst_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
